// File: rtl/alu.sv
// 32-bit single-cycle ALU with a registered result.
// Eight operations: add, sub, and, or, logical/arithmetic right shift,
// left shift and signed less-than. The result is computed combinationally
// from the current inputs and captured into C on each rising clock edge.
module alu (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [2:0]  ALUOp,
  output logic [31:0] C
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_SRL = 3'b100;
  localparam logic [2:0] OP_SRA = 3'b101;
  localparam logic [2:0] OP_SLL = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  logic [31:0] c_reg;
  logic [31:0] c_next;

  // Only the low five bits of B steer the shifters; the rest are ignored.
  logic [4:0]  shamt;
  logic        sr_fill;
  logic        lt;

  // Log-depth barrel shifters: stage gi conditionally shifts by 2**gi.
  logic [31:0] sr_stage [0:5];
  logic [31:0] sl_stage [0:5];

  assign shamt       = B[4:0];
  assign sr_fill     = (ALUOp == OP_SRA) ? A[31] : 1'b0;
  assign sr_stage[0] = A;
  assign sl_stage[0] = A;

  genvar gi;
  generate
    for (gi = 0; gi < 5; gi = gi + 1) begin : g_shift
      localparam int SH = 1 << gi;
      assign sr_stage[gi+1] = shamt[gi]
                            ? {{SH{sr_fill}}, sr_stage[gi][31:SH]}
                            : sr_stage[gi];
      assign sl_stage[gi+1] = shamt[gi]
                            ? {sl_stage[gi][31-SH:0], {SH{1'b0}}}
                            : sl_stage[gi];
    end
  endgenerate

  // Signed comparison in two's complement.
  assign lt = ($signed(A) < $signed(B));

  // Select the result of the requested operation; add/sub wrap silently.
  always_comb begin
    c_next = 32'h0000_0000;
    case (ALUOp)
      OP_ADD:  c_next = A + B;
      OP_SUB:  c_next = A - B;
      OP_AND:  c_next = A & B;
      OP_OR:   c_next = A | B;
      OP_SRL:  c_next = sr_stage[5];
      OP_SRA:  c_next = sr_stage[5];
      OP_SLL:  c_next = sl_stage[5];
      OP_SLT:  c_next = {31'd0, lt};
      default: c_next = 32'h0000_0000;
    endcase
  end

  // Output register; reset wins over the operation sampled at the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      c_reg <= 32'h0000_0000;
    end else begin
      c_reg <= c_next;
    end
  end

  assign C = c_reg;

endmodule

// File: tb/tb_alu.sv
// Directed, table-driven bench for the registered ALU.
module tb_alu;

  logic        clk;
  logic        reset;
  logic [31:0] A;
  logic [31:0] B;
  logic [2:0]  ALUOp;
  logic [31:0] C;

  int total;
  int bad;

  alu dut (
    .clk   (clk),
    .reset (reset),
    .A     (A),
    .B     (B),
    .ALUOp (ALUOp),
    .C     (C)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic [31:0] c;
  } vec_t;

  vec_t vecs [0:21];

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end else begin
      $display("ok   %s: 0x%08h", name, actual);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;

    vecs[0]  = '{"sra_8",        32'hF0F0F0F0, 32'h00000008, 3'b101, 32'hFFF0F0F0};
    vecs[1]  = '{"srl_8",        32'hF0F0F0F0, 32'h00000008, 3'b100, 32'h00F0F0F0};
    vecs[2]  = '{"srl_mask_21",  32'hF0F0F0F0, 32'h00000021, 3'b100, 32'h78787878};
    vecs[3]  = '{"add_wrap",     32'hFFFFFFFF, 32'h00000001, 3'b000, 32'h00000000};
    vecs[4]  = '{"sub_wrap",     32'h00000000, 32'h00000001, 3'b001, 32'hFFFFFFFF};
    vecs[5]  = '{"and",          32'hF0F0F0F0, 32'h0FF00FF0, 3'b010, 32'h00F000F0};
    vecs[6]  = '{"or",           32'hF0F0F0F0, 32'h0FF00FF0, 3'b011, 32'hFFF0FFF0};
    vecs[7]  = '{"sll_31",       32'h00000001, 32'h0000001F, 3'b110, 32'h80000000};
    vecs[8]  = '{"slt_neg_pos",  32'h80000000, 32'h00000001, 3'b111, 32'h00000001};
    vecs[9]  = '{"slt_pos_neg",  32'h00000001, 32'h80000000, 3'b111, 32'h00000000};
    vecs[10] = '{"slt_equal",    32'h00000005, 32'h00000005, 3'b111, 32'h00000000};
    vecs[11] = '{"add_plain",    32'h12345678, 32'h11111111, 3'b000, 32'h23456789};
    vecs[12] = '{"sub_plain",    32'h0000000A, 32'h00000003, 3'b001, 32'h00000007};
    vecs[13] = '{"sll_4",        32'h0000F00F, 32'h00000004, 3'b110, 32'h000F00F0};
    vecs[14] = '{"sra_pos",      32'h70000000, 32'h00000004, 3'b101, 32'h07000000};
    vecs[15] = '{"srl_zero_amt", 32'hDEADBEEF, 32'hFFFFFFE0, 3'b100, 32'hDEADBEEF};
    vecs[16] = '{"sra_31",       32'h80000000, 32'h0000001F, 3'b101, 32'hFFFFFFFF};
    vecs[17] = '{"srl_31",       32'h80000000, 32'h0000001F, 3'b100, 32'h00000001};
    vecs[18] = '{"slt_m1_0",     32'hFFFFFFFF, 32'h00000000, 3'b111, 32'h00000001};
    vecs[19] = '{"sll_mask_3f",  32'hFFFFFFFF, 32'h0000003F, 3'b110, 32'h80000000};
    vecs[20] = '{"slt_3_7",      32'h00000003, 32'h00000007, 3'b111, 32'h00000001};
    vecs[21] = '{"sub_ovf",      32'h80000000, 32'h00000001, 3'b001, 32'h7FFFFFFF};

    // Reset for two edges with non-zero operands present.
    reset = 1'b1;
    A     = 32'h12345678;
    B     = 32'h87654321;
    ALUOp = 3'b011;
    @(posedge clk); #1;
    check("reset_edge1", C, 32'h0);
    @(posedge clk); #1;
    check("reset_edge2", C, 32'h0);

    // Table vectors: one result per edge, first one right after reset drops.
    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      reset = 1'b0;
      A     = vecs[i].a;
      B     = vecs[i].b;
      ALUOp = vecs[i].op;
      @(posedge clk); #1;
      check(vecs[i].name, C, vecs[i].c);
    end

    // C holds between edges while inputs change (last result was 0x7FFFFFFF).
    #2;
    A     = 32'h00000001;
    B     = 32'h00000001;
    ALUOp = 3'b000;
    #1;
    check("hold_between_edges", C, 32'h7FFFFFFF);
    @(posedge clk); #1;
    check("after_hold_edge", C, 32'h00000002);

    // Reset raised between edges must not affect C until an edge.
    @(negedge clk);
    A     = 32'h00000003;
    B     = 32'h00000004;
    ALUOp = 3'b000;
    reset = 1'b1;
    #2;
    check("reset_no_edge", C, 32'h00000002);

    // Reset mid-operation discards the ADD sampled at that edge.
    @(posedge clk); #1;
    check("reset_mid_op", C, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    check("after_reset_add", C, 32'h00000007);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
